cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL provide parameter CTRL_W, default 3, width of gated control vector (bit0 PCS, bit1 RegW, bit2 MemW; range 1..16).
REQ-002 SHALL provide parameter DEPTH, default 4, pending flag-writer FIFO depth (power of two, 2..16).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports: clk in 1 clock; reset in 1 async active-low reset.
REQ-005 SHALL have in_valid in 1 instruction presented; in_ready out 1 instruction accepted this cycle.
REQ-006 SHALL have cond in 4 ARM condition field; flag_w in 2 flag-write mask ([1]=NZ, [0]=CV); ctrl_in in CTRL_W ungated controls.
REQ-007 SHALL have flag_valid in 1 ALU flag result arrives; alu_flags in 4 {N,Z,C,V}.
REQ-008 SHALL have out_valid out 1; ctrl_out out CTRL_W gated controls; cond_ex out 1 condition passed.
REQ-009 SHALL have flags out 4 committed NZCV; stall out 1; pend_cnt out $clog2(DEPTH)+1; flag_err out 1 sticky.

Function
REQ-010 SHALL evaluate all 16 codes on committed flags: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
REQ-011 SHALL set in_ready=0 when cond!=AL and pend_cnt!=0 (flag hazard), or when flag_w!=0 and pend_cnt==DEPTH (full); else in_ready=1.
REQ-012 SHALL drive stall = in_valid & ~in_ready, combinationally.
REQ-013 SHALL, on accept (in_valid&in_ready), register next cycle: out_valid=1, cond_ex, ctrl_out = ctrl_in AND replicated cond_ex; latency exactly 1 cycle.
REQ-014 SHALL drive out_valid=0 and ctrl_out=0 in cycles following no accept.
REQ-015 SHALL push flag_w into FIFO on accept only if flag_w!=0 and cond_ex=1; failed-condition writers push nothing.
REQ-016 SHALL, on flag_valid with FIFO non-empty, pop head mask and update flags[3:2] if mask[1], flags[1:0] if mask[0], visible next cycle.
REQ-017 SHALL, on flag_valid with FIFO empty, leave flags and pend_cnt unchanged and set flag_err=1 until reset.
REQ-018 SHALL, on simultaneous push and pop, keep pend_cnt unchanged and preserve FIFO order; pointers wrap modulo DEPTH.
REQ-019 SHALL treat cond=AL instructions as never hazard-stalled regardless of pend_cnt.
REQ-020 SHALL ignore cond, flag_w, ctrl_in when in_valid=0.

Reset
REQ-021 SHALL, on reset low, asynchronously clear flags=0000, FIFO pointers, pend_cnt=0, out_valid=0, ctrl_out=0, cond_ex=0, flag_err=0.
REQ-022 SHALL discard all pending flag writers on reset mid-operation; flag_valid during reset is ignored.
REQ-023 SHALL resume accepting on first clk edge after reset deasserts (in_ready=1 with empty FIFO).

Configuration
REQ-024 SHALL use macro COND_UNIT_BYPASS_EN.
REQ-025 SHALL, with COND_UNIT_BYPASS_EN defined, not hazard-stall when pend_cnt==1 and flag_valid pops that entry in the same cycle (no push); cond evaluated on forwarded next-flags value.
REQ-026 SHALL, without COND_UNIT_BYPASS_EN, stall in that case, accepting one cycle later on committed flags.

Verification
REQ-027 SHALL cover: reset, flags=0000, cond=0000 EQ, ctrl_in=111 -> next cycle out_valid=1, cond_ex=0, ctrl_out=000.
REQ-028 SHALL cover: AL, flag_w=11 accepted; then EQ presented -> stall=1; flag_valid alu_flags=0100 -> flags=0100, EQ accepted, ctrl_out=ctrl_in.
REQ-029 SHALL cover: four AL flag writers with DEPTH=4, no flag_valid -> pend_cnt=4, fifth writer stall=1; AL with flag_w=00 still accepted.
REQ-030 SHALL cover: flag_w=10 pending, flag_valid alu_flags=1111 -> flags[3:2]=11, flags[1:0] unchanged.
REQ-031 SHALL cover: flag_valid with pend_cnt=0 -> flag_err=1, flags unchanged; reset low mid-stream with pend_cnt=3 -> pend_cnt=0, flag_err=0 immediately.
REQ-032 SHALL cover: pend_cnt=1, GE presented with flag_valid alu_flags=1001 -> accepted same cycle, cond_ex=1, with COND_UNIT_BYPASS_EN; one-cycle stall without.

Source files
------------

// File: rtl/cond_unit.sv
// ARM-style condition unit: gates instruction controls on committed NZCV flags
// and tracks in-flight flag writers in a small FIFO. Optional macro: COND_UNIT_BYPASS_EN.
module cond_unit #(
    parameter int CTRL_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               cond,
    input  logic [1:0]               flag_w,
    input  logic [CTRL_W-1:0]        ctrl_in,
    input  logic                     flag_valid,
    input  logic [3:0]               alu_flags,
    output logic                     out_valid,
    output logic [CTRL_W-1:0]        ctrl_out,
    output logic                     cond_ex,
    output logic [3:0]               flags,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   pend_cnt,
    output logic                     flag_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] ZERO_CNT = CW'(0);

    // Flags are packed {N,Z,C,V}; 4'hF is the reserved never-execute code.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic res;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'h0:    res = z;
            4'h1:    res = ~z;
            4'h2:    res = cy;
            4'h3:    res = ~cy;
            4'h4:    res = n;
            4'h5:    res = ~n;
            4'h6:    res = v;
            4'h7:    res = ~v;
            4'h8:    res = cy & ~z;
            4'h9:    res = ~cy | z;
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = ~z & (n == v);
            4'hD:    res = z | (n != v);
            4'hE:    res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [3:0]        flags_q, flags_d;
    logic [1:0]        mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              flag_err_q, flag_err_d;
    logic              out_valid_q, out_valid_d;
    logic              cond_ex_q, cond_ex_d;
    logic [CTRL_W-1:0] ctrl_out_q, ctrl_out_d;

    logic [1:0]        head_s;
    logic              pop_s;
    logic              push_s;
    logic              accept_s;
    logic              hazard_s;
    logic              full_s;
    logic              bypass_s;
    logic              cond_pass_s;
    logic [3:0]        flags_nxt_s;
    logic [3:0]        eval_flags_s;

    assign head_s = mem_q[rd_ptr_q];
    assign pop_s  = flag_valid & (cnt_q != ZERO_CNT);

    // Committed flags after this cycle's ALU result retires (if any).
    always_comb begin
        flags_nxt_s = flags_q;
        if (pop_s) begin
            if (head_s[1]) begin
                flags_nxt_s[3:2] = alu_flags[3:2];
            end else begin
                flags_nxt_s[3:2] = flags_q[3:2];
            end
            if (head_s[0]) begin
                flags_nxt_s[1:0] = alu_flags[1:0];
            end else begin
                flags_nxt_s[1:0] = flags_q[1:0];
            end
        end else begin
            flags_nxt_s = flags_q;
        end
    end

`ifdef COND_UNIT_BYPASS_EN
    // The last outstanding writer retiring this cycle clears the hazard; evaluate on its result.
    assign bypass_s     = (cnt_q == ONE_CNT) & flag_valid;
    assign eval_flags_s = flags_nxt_s;
`else
    assign bypass_s     = 1'b0;
    assign eval_flags_s = flags_q;
`endif

    assign hazard_s    = (cond != 4'hE) & (cnt_q != ZERO_CNT) & ~bypass_s;
    assign full_s      = (flag_w != 2'b00) & (cnt_q == FULL_CNT);
    assign in_ready    = ~(hazard_s | full_s);
    assign stall       = in_valid & ~in_ready;
    assign accept_s    = in_valid & in_ready;
    assign cond_pass_s = cond_pass(cond, eval_flags_s);
    assign push_s      = accept_s & (flag_w != 2'b00) & cond_pass_s;

    // FIFO bookkeeping, flag commit and sticky underflow error.
    always_comb begin
        flags_d    = flags_nxt_s;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        flag_err_d = flag_err_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + ONE_CNT;
            2'b01:   cnt_d = cnt_q - ONE_CNT;
            default: cnt_d = cnt_q;
        endcase
        if (flag_valid && (cnt_q == ZERO_CNT)) begin
            flag_err_d = 1'b1;
        end else begin
            flag_err_d = flag_err_q;
        end
    end

    // Registered instruction result; dropped cycles present zeroed controls.
    always_comb begin
        out_valid_d = accept_s;
        cond_ex_d   = 1'b0;
        ctrl_out_d  = {CTRL_W{1'b0}};
        if (accept_s) begin
            cond_ex_d  = cond_pass_s;
            ctrl_out_d = ctrl_in & {CTRL_W{cond_pass_s}};
        end else begin
            cond_ex_d  = 1'b0;
            ctrl_out_d = {CTRL_W{1'b0}};
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q     <= 4'b0000;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            cnt_q       <= ZERO_CNT;
            flag_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cond_ex_q   <= 1'b0;
            ctrl_out_q  <= {CTRL_W{1'b0}};
        end else begin
            flags_q     <= flags_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            flag_err_q  <= flag_err_d;
            out_valid_q <= out_valid_d;
            cond_ex_q   <= cond_ex_d;
            ctrl_out_q  <= ctrl_out_d;
        end
    end

    // Pending flag-write masks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= flag_w;
        end
    end

    assign flags     = flags_q;
    assign pend_cnt  = cnt_q;
    assign flag_err  = flag_err_q;
    assign out_valid = out_valid_q;
    assign cond_ex   = cond_ex_q;
    assign ctrl_out  = ctrl_out_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit (DEPTH=4, CTRL_W=3).
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cond;
    logic [1:0] flag_w;
    logic [2:0] ctrl_in;
    logic       flag_valid;
    logic [3:0] alu_flags;
    logic       out_valid;
    logic [2:0] ctrl_out;
    logic       cond_ex;
    logic [3:0] flags;
    logic       stall;
    logic [2:0] pend_cnt;
    logic       flag_err;

    int errors = 0;
    int checks = 0;

    cond_unit #(.CTRL_W(3), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .flag_w(flag_w), .ctrl_in(ctrl_in), .flag_valid(flag_valid),
        .alu_flags(alu_flags), .out_valid(out_valid), .ctrl_out(ctrl_out),
        .cond_ex(cond_ex), .flags(flags), .stall(stall), .pend_cnt(pend_cnt),
        .flag_err(flag_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 1'b0; cond = 4'hE; flag_w = 2'b00; ctrl_in = 3'b000;
        flag_valid = 1'b0; alu_flags = 4'b0000;
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] fw, input logic [2:0] ct);
        in_valid = 1'b1; cond = c; flag_w = fw; ctrl_in = ct;
    endtask

    // Setup: retire one AL writer carrying f (requires empty FIFO).
    task automatic set_flags(input logic [3:0] f);
        issue(4'hE, 2'b11, 3'b000);
        tick;
        in_valid = 1'b0; flag_valid = 1'b1; alu_flags = f;
        tick;
        idle;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", flags); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL rst_pend: got %0d want 0", pend_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ovalid: got %b want 0", out_valid); end
        checks++; if (flag_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", flag_err); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        tick;
    endtask

    task automatic test_eq_fail;
        issue(4'h0, 2'b00, 3'b111);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL eq_ready: got %b want 1", in_ready); end
        tick;
        idle;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL eq_ovalid: got %b want 1", out_valid); end
        checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL eq_condex: got %b want 0", cond_ex); end
        checks++; if (ctrl_out !== 3'b000) begin errors++; $display("FAIL eq_ctrl: got %b want 000", ctrl_out); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL eq_idle_ovalid: got %b want 0", out_valid); end
    endtask

    task automatic test_hazard;
        issue(4'hE, 2'b11, 3'b101);
        tick;
        checks++; if (ctrl_out !== 3'b101) begin errors++; $display("FAIL hz_al_ctrl: got %b want 101", ctrl_out); end
        checks++; if (pend_cnt !== 3'd1) begin errors++; $display("FAIL hz_pend1: got %0d want 1", pend_cnt); end
        issue(4'h0, 2'b00, 3'b011);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hz_stall: got %b want 1", stall); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hz_no_out: got %b want 0", out_valid); end
        in_valid = 1'b0; flag_valid = 1'b1; alu_flags = 4'b0100;
        tick;
        flag_valid = 1'b0;
        checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL hz_flags: got %b want 0100", flags); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL hz_pend0: got %0d want 0", pend_cnt); end
        issue(4'h0, 2'b00, 3'b011);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hz_ready: got %b want 1", in_ready); end
        tick;
        idle;
        checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL hz_condex: got %b want 1", cond_ex); end
        checks++; if (ctrl_out !== 3'b011) begin errors++; $display("FAIL hz_ctrl: got %b want 011", ctrl_out); end
    endtask

    task automatic test_full;
        issue(4'hE, 2'b01, 3'b111);
        repeat (4) tick;
        checks++; if (pend_cnt !== 3'd4) begin errors++; $display("FAIL full_pend4: got %0d want 4", pend_cnt); end
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", stall); end
        flag_w = 2'b00;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_nowrite_stall: got %b want 0", stall); end
        tick;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_nowrite_out: got %b want 1", out_valid); end
        checks++; if (pend_cnt !== 3'd4) begin errors++; $display("FAIL full_pend_hold: got %0d want 4", pend_cnt); end
        flag_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_flags = (i == 3) ? 4'b1011 : 4'b0000;
            tick;
            if (i == 0) begin
                checks++; if (pend_cnt !== 3'd3) begin errors++; $display("FAIL full_pend3: got %0d want 3", pend_cnt); end
            end
        end
        idle;
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d want 0", pend_cnt); end
        checks++; if (flags !== 4'b0111) begin errors++; $display("FAIL full_flags: got %b want 0111", flags); end
    endtask

    task automatic test_partial;
        set_flags(4'b0100);
        issue(4'hE, 2'b10, 3'b000);
        tick;
        in_valid = 1'b0; flag_valid = 1'b1; alu_flags = 4'b1111;
        tick;
        idle;
        checks++; if (flags !== 4'b1100) begin errors++; $display("FAIL part_flags: got %b want 1100", flags); end
        issue(4'h1, 2'b11, 3'b111);
        tick;
        idle;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nopush_out: got %b want 1", out_valid); end
        checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL nopush_condex: got %b want 0", cond_ex); end
        checks++; if (ctrl_out !== 3'b000) begin errors++; $display("FAIL nopush_ctrl: got %b want 000", ctrl_out); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL nopush_pend: got %0d want 0", pend_cnt); end
    endtask

    task automatic test_cond_codes;
        logic [3:0]  pat [4];
        logic [15:0] exp [4];
        logic [15:0] e;
        pat[0] = 4'b0000; exp[0] = 16'h56AA;
        pat[1] = 4'b0110; exp[1] = 16'h66A5;
        pat[2] = 4'b1010; exp[2] = 16'h6996;
        pat[3] = 4'b1001; exp[3] = 16'h565A;
        for (int p = 0; p < 4; p++) begin
            set_flags(pat[p]);
            e = exp[p];
            for (int c = 0; c < 16; c++) begin
                issue(4'(c), 2'b00, 3'b101);
                tick;
                checks++; if (cond_ex !== e[c]) begin errors++; $display("FAIL cc_%0h_f%b: got %b want %b", c, pat[p], cond_ex, e[c]); end
                checks++; if (ctrl_out !== (e[c] ? 3'b101 : 3'b000)) begin errors++; $display("FAIL cc_ctrl_%0h_f%b: got %b want %b", c, pat[p], ctrl_out, e[c] ? 3'b101 : 3'b000); end
            end
            idle;
        end
    endtask

    task automatic test_back_to_back;
        issue(4'hE, 2'b10, 3'b001);
        tick;
        issue(4'hE, 2'b01, 3'b001);
        flag_valid = 1'b1; alu_flags = 4'b0100;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        tick;
        checks++; if (pend_cnt !== 3'd1) begin errors++; $display("FAIL b2b_pend: got %0d want 1", pend_cnt); end
        checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL b2b_flags1: got %b want 0101", flags); end
        in_valid = 1'b0; alu_flags = 4'b0010;
        tick;
        idle;
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL b2b_pend0: got %0d want 0", pend_cnt); end
        checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL b2b_flags2: got %b want 0110", flags); end
    endtask

    task automatic test_bypass;
        set_flags(4'b1000);
        issue(4'hE, 2'b11, 3'b000);
        tick;
        issue(4'hA, 2'b00, 3'b111);
        flag_valid = 1'b1; alu_flags = 4'b1001;
`ifdef COND_UNIT_BYPASS_EN
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL byp_ready: got %b want 1", in_ready); end
        tick;
        idle;
`else
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL byp_stall: got %b want 1", stall); end
        tick;
        flag_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL byp_noout: got %b want 0", out_valid); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL byp_ready_late: got %b want 1", in_ready); end
        tick;
        idle;
`endif
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL byp_out: got %b want 1", out_valid); end
        checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL byp_condex: got %b want 1", cond_ex); end
        checks++; if (ctrl_out !== 3'b111) begin errors++; $display("FAIL byp_ctrl: got %b want 111", ctrl_out); end
        checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL byp_flags: got %b want 1001", flags); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL byp_pend: got %0d want 0", pend_cnt); end
    endtask

    task automatic test_err_reset;
        flag_valid = 1'b1; alu_flags = 4'b1111;
        tick;
        flag_valid = 1'b0;
        checks++; if (flag_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", flag_err); end
        checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL err_flags: got %b want 1001", flags); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL err_pend: got %0d want 0", pend_cnt); end
        tick;
        checks++; if (flag_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", flag_err); end
        issue(4'hE, 2'b11, 3'b000);
        repeat (3) tick;
        idle;
        checks++; if (pend_cnt !== 3'd3) begin errors++; $display("FAIL rst_mid_pend3: got %0d want 3", pend_cnt); end
        #2;
        reset = 1'b0;
        flag_valid = 1'b1; alu_flags = 4'b1111;
        #1;
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL rst_mid_pend: got %0d want 0", pend_cnt); end
        checks++; if (flag_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b want 0", flag_err); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b want 0000", flags); end
        tick;
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rst_fv_ignored: got %b want 0000", flags); end
        reset = 1'b1;
        idle;
        issue(4'hE, 2'b11, 3'b110);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_resume_ready: got %b want 1", in_ready); end
        tick;
        idle;
        checks++; if (ctrl_out !== 3'b110) begin errors++; $display("FAIL rst_resume_ctrl: got %b want 110", ctrl_out); end
        checks++; if (pend_cnt !== 3'd1) begin errors++; $display("FAIL rst_resume_pend: got %0d want 1", pend_cnt); end
    endtask

    initial begin
        test_reset;
        test_eq_fail;
        test_hazard;
        test_full;
        test_partial;
        test_cond_codes;
        test_back_to_back;
        test_bypass;
        test_err_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
